button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Conditions a raw push-button or switch input from the board before it reaches the 4-bit counter/seven-segment datapath.
- Synchronizes the input to the system clock and filters contact bounce with a stability counter.
- Outputs a clean level plus single-cycle press and release strobes.
- press_pulse replaces the raw button as the counter's step event. The downstream counter then runs on the system clock with press_pulse as its enable.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles the synchronized input must hold a new level before it is accepted (5 ms at 100 MHz). Legal range is 2 or more.
- REPEAT_CYCLES, 25000000, auto-repeat period in clk cycles. Used only when the optional feature is compiled in. Legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- noisy_in  input  1  raw asynchronous button level; active-high.
- debounced  output  1  filtered level of noisy_in.
- press_pulse  output  1  one-clk strobe on an accepted 0->1 transition (and on auto-repeat, if enabled).
- release_pulse  output  1  one-clk strobe on an accepted 1->0 transition.

Behaviour:
- Reset:
  - While rst_n=0, all flops clear immediately, regardless of clk: synchronizer, counter, state=S_IDLE.
  - Outputs during reset: debounced=0, press_pulse=0, release_pulse=0.
  - Reset asserted mid-count or while S_PRESSED discards all progress. No release_pulse is generated.
- Synchronizer: noisy_in passes through two flops, giving sync_in. No logic reads noisy_in directly.
- Counter: width $clog2(DEBOUNCE_CYCLES). It never exceeds DEBOUNCE_CYCLES-1, so no wrap.
- State machine, four states (all outputs registered):
  - S_IDLE (debounced=0): if sync_in=1, go to S_WAIT_HIGH and set cnt=0.
  - S_WAIT_HIGH (debounced=0):
    - if sync_in=0, return to S_IDLE (bounce rejected, no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to S_PRESSED;
    - else cnt++.
  - S_PRESSED (debounced=1): if sync_in=0, go to S_WAIT_LOW and set cnt=0.
  - S_WAIT_LOW (debounced=1):
    - if sync_in=1, return to S_PRESSED (no pulse);
    - else if cnt==DEBOUNCE_CYCLES-1, go to S_IDLE;
    - else cnt++.
- Output timing:
  - debounced equals 1 exactly when state is S_PRESSED or S_WAIT_LOW; it is registered alongside the state.
  - press_pulse=1 for exactly the one cycle following the S_WAIT_HIGH->S_PRESSED transition.
  - release_pulse=1 for exactly the one cycle following the S_WAIT_LOW->S_IDLE transition.
  - press_pulse and release_pulse are never asserted together.
- Latency: if noisy_in rises cleanly just before edge E1, debounced and press_pulse are first seen high after edge E1+DEBOUNCE_CYCLES+2. Release latency is identical.
- Bounce rule: any glitch visible at sync_in restarts qualification from zero. A glitch of one cycle or more inside a wait state aborts that wait.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - A second counter rcnt (width $clog2(REPEAT_CYCLES)) clears on entry to S_PRESSED and increments while in S_PRESSED.
  - On rcnt==REPEAT_CYCLES-1, press_pulse asserts for one cycle and rcnt returns to 0.
  - rcnt holds its value in S_WAIT_LOW. It clears if the block returns to S_PRESSED from S_WAIT_LOW.
  - debounced and release_pulse are unaffected.
- Undefined: no rcnt logic exists; press_pulse fires only once per accepted press.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] debounce_state_t {S_IDLE, S_WAIT_HIGH, S_PRESSED, S_WAIT_LOW};
  - localparam DEFAULT_DEBOUNCE_CYCLES=500000;
  - localparam DEFAULT_REPEAT_CYCLES=25000000.
- Sub-module sync_2ff: two-flop synchronizer with clk and rst_n (async reset to 0), 1-bit d in, 1-bit q out. Instanced once here and reusable for the sw inputs.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20, 10 ns clk):
- Reset: hold rst_n=0 for 3 cycles with noisy_in=1, then release -> all outputs 0 during reset. After release, press_pulse fires exactly once, 11 edges later.
- Clean press/release: noisy_in 0->1 held 40 cycles, then 1->0 -> debounced rises with a single-cycle press_pulse 11 edges after the rise. It falls with a single-cycle release_pulse 11 edges after the fall.
- Bounce: toggle noisy_in every 3 cycles for 30 cycles, then hold 1 -> no pulses during toggling. Exactly one press_pulse 11 edges after the final stable rise.
- Release glitch: while debounced=1, drop noisy_in low for 4 cycles, then restore -> debounced stays 1; no release_pulse.
- Async reset mid-count: assert rst_n=0 at cnt=5 in S_WAIT_HIGH, off a clk edge -> outputs 0 immediately; state S_IDLE; no pulse.
- BUTTON_DEBOUNCER_AUTOREPEAT_EN defined, hold noisy_in=1 for 100 cycles -> initial press_pulse, then one press_pulse every 20 cycles (4 repeats). Without the macro, exactly one press_pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Contents:
//   debounce_state_t        - debouncer FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES - 5 ms stability window at 100 MHz
//   DEFAULT_REPEAT_CYCLES   - 250 ms auto-repeat period at 100 MHz
package debounce_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_PRESSED   = 2'd2,
        S_WAIT_LOW  = 2'd3
    } debounce_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// The same block can be used for any other board switch input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops clear to 0
//   d     - asynchronous input level
//   q     - level synchronized to clk, two cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer. It synchronizes the raw button and accepts a new
// level only after the level has been stable for DEBOUNCE_CYCLES clocks.
// It produces a clean level and one-cycle press and release strobes.
// Optional build macro BUTTON_DEBOUNCER_AUTOREPEAT_EN: while the button
// stays pressed, press_pulse repeats every REPEAT_CYCLES clocks.
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   noisy_in      - raw asynchronous button level, active-high
//   debounced     - filtered button level
//   press_pulse   - one-clk strobe on an accepted press (and on auto-repeat)
//   release_pulse - one-clk strobe on an accepted release
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | released and stable; debounced=0
// S_WAIT_HIGH | input went high; counting stability; debounced=0
// S_PRESSED   | pressed and stable; debounced=1
// S_WAIT_LOW  | input went low; counting stability; debounced=1
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_in,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_debouncer: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic            w_sync_in;
    debounce_state_t r_state;
    debounce_state_t w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic            r_debounced;
    logic            r_press;
    logic            r_release;
    logic            w_press_edge;
    logic            w_release_next;
    logic            w_repeat;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (noisy_in),
        .q     (w_sync_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_debounced <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_debounced <= (w_state_next == S_PRESSED) || (w_state_next == S_WAIT_LOW);
            r_press     <= w_press_edge | w_repeat;
            r_release   <= w_release_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_press_edge   = 1'b0;
        w_release_next = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_sync_in) begin
                    w_state_next = S_WAIT_HIGH;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!w_sync_in) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = S_PRESSED;
                    w_press_edge = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                if (!w_sync_in) begin
                    w_state_next = S_WAIT_LOW;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (w_sync_in) begin
                    w_state_next = S_PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = S_IDLE;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int RCNT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    logic [RCNT_W-1:0] r_rcnt;
    logic [RCNT_W-1:0] w_rcnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcnt <= '0;
        end else begin
            r_rcnt <= w_rcnt_next;
        end
    end

    // The repeat period counts only while the press stays put; a release
    // attempt freezes it, and any (re)entry to S_PRESSED starts a new period.
    always_comb begin
        w_rcnt_next = r_rcnt;
        w_repeat    = 1'b0;
        if (r_state == S_PRESSED && w_state_next == S_PRESSED) begin
            if (r_rcnt == RCNT_LAST) begin
                w_rcnt_next = '0;
                w_repeat    = 1'b1;
            end else begin
                w_rcnt_next = r_rcnt + RCNT_W'(1);
            end
        end else if (w_state_next == S_PRESSED && r_state != S_PRESSED) begin
            w_rcnt_next = '0;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign debounced     = r_debounced;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20.
// An accepted edge shows up 11 clock edges after the input change.
module tb_button_debouncer;

    localparam int DB = 8;
    localparam int RP = 20;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic rst_n;
    logic noisy_in;
    logic debounced;
    logic press_pulse;
    logic release_pulse;

    int n_checks = 0;
    int n_errors = 0;

    int np, fp, lp, nr, fr, fchg, ovl;
    int acc_np, acc_nr, acc_chg, acc_ovl;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .noisy_in      (noisy_in),
        .debounced     (debounced),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n clock edges, recording where pulses and level changes appear
    // (edge index 1..n relative to the start of the window).
    task automatic run_window(input int n, output int o_np, output int o_fp, output int o_lp,
                              output int o_nr, output int o_fr, output int o_fchg, output int o_ovl);
        logic d0;
        d0 = debounced;
        o_np = 0; o_fp = -1; o_lp = -1; o_nr = 0; o_fr = -1; o_fchg = -1; o_ovl = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (press_pulse === 1'b1) begin
                o_np++;
                if (o_fp < 0) o_fp = k;
                o_lp = k;
            end
            if (release_pulse === 1'b1) begin
                o_nr++;
                if (o_fr < 0) o_fr = k;
            end
            if (press_pulse === 1'b1 && release_pulse === 1'b1) o_ovl++;
            if (o_fchg < 0 && debounced !== d0) o_fchg = k;
        end
    endtask

    task automatic test_reset();
        noisy_in = 1'b1;
        rst_n    = 1'b0;
        #1;
        n_checks++;
        if ({debounced, press_pulse, release_pulse} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_immediate: outputs=%b expected 000", {debounced, press_pulse, release_pulse});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({debounced, press_pulse, release_pulse} !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_hold cycle %0d: outputs=%b expected 000", i, {debounced, press_pulse, release_pulse});
            end
        end
        rst_n = 1'b1;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (np !== 1 || fp !== LAT) begin
            n_errors++;
            $display("FAIL reset_release_press: count=%0d first=%0d expected count=1 first=%0d", np, fp, LAT);
        end
        n_checks++;
        if (fchg !== LAT || debounced !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_level: rise_at=%0d level=%b expected rise_at=%0d level=1", fchg, debounced, LAT);
        end
        n_checks++;
        if (nr !== 0 || ovl !== 0) begin
            n_errors++;
            $display("FAIL reset_release_other: releases=%0d overlaps=%0d expected 0 0", nr, ovl);
        end
    endtask

    task automatic test_clean_press_release();
        int exp_np;
        int exp_lp;
        noisy_in = 1'b0;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (nr !== 1 || fr !== LAT || fchg !== LAT || np !== 0 || debounced !== 1'b0) begin
            n_errors++;
            $display("FAIL clean_release_1: rel=%0d at %0d fall_at=%0d press=%0d level=%b expected 1 at %0d fall_at=%0d press=0 level=0",
                     nr, fr, fchg, np, debounced, LAT, LAT);
        end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        exp_np = 2;
        exp_lp = LAT + RP;
`else
        exp_np = 1;
        exp_lp = LAT;
`endif
        noisy_in = 1'b1;
        run_window(40, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (np !== exp_np || fp !== LAT || lp !== exp_lp) begin
            n_errors++;
            $display("FAIL clean_press: count=%0d first=%0d last=%0d expected count=%0d first=%0d last=%0d",
                     np, fp, lp, exp_np, LAT, exp_lp);
        end
        n_checks++;
        if (fchg !== LAT || debounced !== 1'b1 || nr !== 0 || ovl !== 0) begin
            n_errors++;
            $display("FAIL clean_press_level: rise_at=%0d level=%b rel=%0d ovl=%0d expected rise_at=%0d level=1 rel=0 ovl=0",
                     fchg, debounced, nr, ovl, LAT);
        end
        noisy_in = 1'b0;
        run_window(40, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (nr !== 1 || fr !== LAT || fchg !== LAT || np !== 0 || ovl !== 0 || debounced !== 1'b0) begin
            n_errors++;
            $display("FAIL clean_release_2: rel=%0d at %0d fall_at=%0d press=%0d level=%b expected 1 at %0d fall_at=%0d press=0 level=0",
                     nr, fr, fchg, np, debounced, LAT, LAT);
        end
    endtask

    task automatic test_bounce();
        acc_np = 0; acc_nr = 0; acc_chg = 0;
        for (int seg = 0; seg < 10; seg++) begin
            noisy_in = (seg % 2 == 0) ? 1'b1 : 1'b0;
            run_window(3, np, fp, lp, nr, fr, fchg, ovl);
            acc_np += np;
            acc_nr += nr;
            if (fchg >= 0) acc_chg++;
        end
        n_checks++;
        if (acc_np !== 0 || acc_nr !== 0 || acc_chg !== 0) begin
            n_errors++;
            $display("FAIL bounce_reject: press=%0d rel=%0d level_changes=%0d expected 0 0 0", acc_np, acc_nr, acc_chg);
        end
        noisy_in = 1'b1;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (np !== 1 || fp !== LAT || fchg !== LAT || nr !== 0) begin
            n_errors++;
            $display("FAIL bounce_settle: press=%0d at %0d rise_at=%0d rel=%0d expected 1 at %0d rise_at=%0d rel=0",
                     np, fp, fchg, nr, LAT, LAT);
        end
    endtask

    task automatic test_release_glitch();
        acc_np = 0; acc_nr = 0; acc_chg = 0;
        noisy_in = 1'b0;
        run_window(4, np, fp, lp, nr, fr, fchg, ovl);
        acc_np += np; acc_nr += nr;
        if (fchg >= 0) acc_chg++;
        noisy_in = 1'b1;
        run_window(10, np, fp, lp, nr, fr, fchg, ovl);
        acc_np += np; acc_nr += nr;
        if (fchg >= 0) acc_chg++;
        n_checks++;
        if (acc_nr !== 0 || acc_chg !== 0 || debounced !== 1'b1) begin
            n_errors++;
            $display("FAIL release_glitch: rel=%0d level_changes=%0d level=%b expected 0 0 1", acc_nr, acc_chg, debounced);
        end
        n_checks++;
        if (acc_np !== 0) begin
            n_errors++;
            $display("FAIL release_glitch_press: press=%0d expected 0", acc_np);
        end
        noisy_in = 1'b0;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (nr !== 1 || fr !== LAT || debounced !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_then_release: rel=%0d at %0d level=%b expected 1 at %0d level=0", nr, fr, debounced, LAT);
        end
    endtask

    task automatic test_async_reset();
        // Mid-count: 8 edges after the rise the wait counter holds 5.
        noisy_in = 1'b1;
        run_window(8, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (np !== 0 || fchg !== -1) begin
            n_errors++;
            $display("FAIL midcount_pre: press=%0d change_at=%0d expected 0 -1", np, fchg);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({debounced, press_pulse, release_pulse} !== 3'b000) begin
            n_errors++;
            $display("FAIL midcount_reset_outputs: outputs=%b expected 000", {debounced, press_pulse, release_pulse});
        end
        step();
        step();
        rst_n = 1'b1;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (np !== 1 || fp !== LAT || nr !== 0) begin
            n_errors++;
            $display("FAIL midcount_restart: press=%0d at %0d rel=%0d expected 1 at %0d rel=0", np, fp, nr, LAT);
        end
        // Reset while pressed: level must drop off-edge, with no release strobe.
        noisy_in = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (debounced !== 1'b0) begin
            n_errors++;
            $display("FAIL pressed_reset_async: level=%b expected 0", debounced);
        end
        step();
        step();
        rst_n = 1'b1;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (nr !== 0 || np !== 0 || debounced !== 1'b0) begin
            n_errors++;
            $display("FAIL pressed_reset_after: rel=%0d press=%0d level=%b expected 0 0 0", nr, np, debounced);
        end
    endtask

    task automatic test_autorepeat();
        int exp_np;
        int exp_lp;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        exp_np = 5;
        exp_lp = LAT + 4 * RP;
`else
        exp_np = 1;
        exp_lp = LAT;
`endif
        noisy_in = 1'b1;
        run_window(100, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (np !== exp_np || fp !== LAT || lp !== exp_lp) begin
            n_errors++;
            $display("FAIL hold_100: count=%0d first=%0d last=%0d expected count=%0d first=%0d last=%0d",
                     np, fp, lp, exp_np, LAT, exp_lp);
        end
        n_checks++;
        if (nr !== 0 || ovl !== 0 || debounced !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_100_other: rel=%0d ovl=%0d level=%b expected 0 0 1", nr, ovl, debounced);
        end
        noisy_in = 1'b0;
        run_window(20, np, fp, lp, nr, fr, fchg, ovl);
        n_checks++;
        if (nr !== 1 || fr !== LAT || np !== 0) begin
            n_errors++;
            $display("FAIL hold_100_release: rel=%0d at %0d press=%0d expected 1 at %0d press=0", nr, fr, np, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press_release();
        test_bounce();
        test_release_glitch();
        test_async_reset();
        test_autorepeat();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
